// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU stream, long-latency stream, rf write port, hazard/forwarding view.
interface wb_arbiter_if #(
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned W_RFADDR = 5
);
  logic                      alu_valid;
  logic [W_RFADDR-1:0]       alu_dest;
  logic [W_DATA-1:0]         alu_data;
  logic                      alu_stall;
  logic                      lng_valid;
  logic                      lng_ready;
  logic [W_RFADDR-1:0]       lng_dest;
  logic [W_DATA-1:0]         lng_data;
  logic                      rf_we;
  logic [W_RFADDR-1:0]       rf_wr;
  logic [W_DATA-1:0]         rf_wd;
  logic [(1<<W_RFADDR)-1:0]  pend_mask;
  logic [W_RFADDR-1:0]       q_addr;
  logic                      q_hit;
  logic [W_DATA-1:0]         q_data;

  modport slave (
    input  alu_valid, alu_dest, alu_data, lng_valid, lng_dest, lng_data, q_addr,
    output alu_stall, lng_ready, rf_we, rf_wr, rf_wd, pend_mask, q_hit, q_data
  );

  modport master (
    output alu_valid, alu_dest, alu_data, lng_valid, lng_dest, lng_data, q_addr,
    input  alu_stall, lng_ready, rf_we, rf_wr, rf_wd, pend_mask, q_hit, q_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order ALU results with FIFO-buffered long-latency results
// onto the single rf write port, with anti-starvation stall, pending mask and forwarding.
module wb_arbiter #(
  parameter int unsigned W_DATA     = 32,
  parameter int unsigned W_RFADDR   = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
  localparam int unsigned NREG = 1 << W_RFADDR;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_STARVE,
    SRC_ALU,
    SRC_FIFO
  } src_e;

  logic [W_RFADDR-1:0] mem_dest_q [DEPTH];
  logic [W_RFADDR-1:0] mem_dest_d [DEPTH];
  logic [W_DATA-1:0]   mem_data_q [DEPTH];
  logic [W_DATA-1:0]   mem_data_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                rf_we_q, rf_we_d;
  logic [W_RFADDR-1:0] rf_wr_q, rf_wr_d;
  logic [W_DATA-1:0]   rf_wd_q, rf_wd_d;

  src_e                src;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [PW-1:0]       idx;
  logic [NREG-1:0]     pend;
  logic                hit;
  logic [W_DATA-1:0]   hit_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  always_comb begin
    src = SRC_NONE;
    if ((starve_q == SW'(STARVE_MAX)) && !fifo_empty) begin
      src = SRC_STARVE;
    end else if (bus.alu_valid && (bus.alu_dest != '0)) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end
  end

  assign pop           = !rst && ((src == SRC_STARVE) || (src == SRC_FIFO));
  assign bus.lng_ready = !rst && !fifo_full;
  assign bus.alu_stall = !rst && (src == SRC_STARVE);
  // Dest 0 still completes the handshake but is dropped rather than queued.
  assign push          = bus.lng_valid && bus.lng_ready && (bus.lng_dest != '0);

  always_comb begin
    mem_dest_d = mem_dest_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_wr_d    = rf_wr_q;
    rf_wd_d    = rf_wd_q;

    if (pop) begin
      rf_we_d  = 1'b1;
      rf_wr_d  = mem_dest_q[rd_ptr_q];
      rf_wd_d  = mem_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (src == SRC_ALU) begin
      rf_we_d = 1'b1;
      rf_wr_d = bus.alu_dest;
      rf_wd_d = bus.alu_data;
    end

    if (push) begin
      mem_dest_d[wr_ptr_q] = bus.lng_dest;
      mem_data_d[wr_ptr_q] = bus.lng_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wr_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_wr_q  <= rf_wr_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_dest_q <= mem_dest_d;
    mem_data_q <= mem_data_d;
  end

  // Walk oldest->newest so later (newer) matches override; the output register ranks below all.
  always_comb begin
    idx      = '0;
    pend     = '0;
    hit      = 1'b0;
    hit_data = '0;
    if (rf_we_q) begin
      pend[rf_wr_q] = 1'b1;
      if (rf_wr_q == bus.q_addr) begin
        hit      = 1'b1;
        hit_data = rf_wd_q;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pend[mem_dest_q[idx]] = 1'b1;
        if (mem_dest_q[idx] == bus.q_addr) begin
          hit      = 1'b1;
          hit_data = mem_data_q[idx];
        end
      end
    end
    pend[0] = 1'b0;
    if (bus.q_addr == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.pend_mask = pend;
  assign bus.q_hit     = hit;
  assign bus.q_data    = hit_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a behavioural queue model predicts every rf write,
// which is pushed to a scoreboard and compared after the following clock edge.
module tb_wb_arbiter;
  localparam int unsigned WD   = 32;
  localparam int unsigned WA   = 5;
  localparam int unsigned DEP  = 4;
  localparam int unsigned SMAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.W_DATA(WD), .W_RFADDR(WA)) bus ();

  wb_arbiter #(.W_DATA(WD), .W_RFADDR(WA), .DEPTH(DEP), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [WA-1:0] dest;
    logic [WD-1:0] data;
  } ent_t;

  typedef struct packed {
    logic          we;
    logic [WA-1:0] wr;
    logic [WD-1:0] wd;
  } rf_t;

  ent_t          mq[$];
  rf_t           sb[$];
  int unsigned   mstarve;
  logic          m_we;
  logic [WA-1:0] m_wr;
  logic [WD-1:0] m_wd;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic av, input logic [WA-1:0] ad, input logic [WD-1:0] adat,
                     input logic lv, input logic [WA-1:0] ld, input logic [WD-1:0] ldat,
                     input logic [WA-1:0] qa, output logic stalled);
    logic          empty, full, stv, aluw, pop, push, exp_hit;
    logic [WD-1:0] exp_qd;
    logic [31:0]   exp_pm;
    ent_t          h;
    rf_t           e;
    @(negedge clk);
    rst           = r;
    bus.alu_valid = av;
    bus.alu_dest  = ad;
    bus.alu_data  = adat;
    bus.lng_valid = lv;
    bus.lng_dest  = ld;
    bus.lng_data  = ldat;
    bus.q_addr    = qa;
    #1;
    empty   = (mq.size() == 0);
    full    = (mq.size() == DEP);
    stv     = (mstarve == SMAX) && !empty;
    stalled = !r && stv;
    chk("lng_ready", bus.lng_ready, !r && !full);
    chk("alu_stall", bus.alu_stall, !r && stv);

    exp_hit = 1'b0;
    exp_qd  = '0;
    if (qa != 0) begin
      for (int i = int'(mq.size()) - 1; i >= 0 && !exp_hit; i--) begin
        if (mq[i].dest == qa) begin
          exp_hit = 1'b1;
          exp_qd  = mq[i].data;
        end
      end
      if (!exp_hit && m_we && m_wr == qa) begin
        exp_hit = 1'b1;
        exp_qd  = m_wd;
      end
    end
    chk("q_hit", bus.q_hit, exp_hit);
    chk("q_data", bus.q_data, exp_qd);

    exp_pm = '0;
    if (m_we) exp_pm[m_wr] = 1'b1;
    foreach (mq[i]) exp_pm[mq[i].dest] = 1'b1;
    exp_pm[0] = 1'b0;
    chk("pend_mask", bus.pend_mask, exp_pm);

    if (r) begin
      mq.delete();
      mstarve = 0;
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      aluw = !stv && av && (ad != 0);
      pop  = stv || (!aluw && !empty);
      push = lv && !full && (ld != 0);
      if (pop) begin
        h    = mq.pop_front();
        m_we = 1'b1;
        m_wr = h.dest;
        m_wd = h.data;
      end else if (aluw) begin
        m_we = 1'b1;
        m_wr = ad;
        m_wd = adat;
      end else begin
        m_we = 1'b0;
      end
      if (push) mq.push_back(ent_t'{ld, ldat});
      if (empty || pop) mstarve = 0;
      else if (mstarve < SMAX) mstarve++;
    end
    sb.push_back(rf_t'{m_we, m_wr, m_wd});

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rf_we", bus.rf_we, e.we);
    chk("rf_wr", bus.rf_wr, e.wr);
    chk("rf_wd", bus.rf_wd, e.wd);
  endtask

  initial begin
    logic          st;
    logic [WD-1:0] d;
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_dest  = '0;
    bus.alu_data  = '0;
    bus.lng_valid = 1'b0;
    bus.lng_dest  = '0;
    bus.lng_data  = '0;
    bus.q_addr    = '0;
    mstarve = 0;
    m_we    = 1'b0;
    m_wr    = '0;
    m_wd    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_rf_we", bus.rf_we, 1'b0);
    chk("reset_rf_wr", bus.rf_wr, 5'd0);
    chk("reset_rf_wd", bus.rf_wd, 32'd0);
    chk("reset_pend", bus.pend_mask, 32'd0);
    cyc(1, 1, 5'd6, 32'h55, 1, 5'd6, 32'h66, 5'd6, st);

    // single ALU write, then idle with forwarding query on the written register
    cyc(0, 1, 5'd5, 32'h1234, 0, '0, '0, 5'd5, st);
    chk("t1_wr", bus.rf_wr, 5'd5);
    chk("t1_wd", bus.rf_wd, 32'h1234);
    cyc(0, 0, '0, '0, 0, '0, '0, 5'd5, st);
    cyc(0, 0, '0, '0, 0, '0, '0, 5'd5, st);

    // back-to-back long results with ALU idle drain in order
    for (int i = 1; i <= 4; i++) cyc(0, 0, '0, '0, 1, WA'(i), 32'h100 + 32'(i), WA'(i), st);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 0, '0, '0, 5'd4, st);

    // ALU saturating the port starves one queued long result until the forced drain
    d = 32'h700;
    for (int k = 0; k < 14; k++) begin
      cyc(0, 1, 5'd7, d, k == 0, 5'd9, 32'h999, 5'd9, st);
      if (!st) d++;
    end
    cyc(0, 0, '0, '0, 0, '0, '0, 5'd7, st);

    // dest 0 on either stream never writes
    cyc(0, 0, '0, '0, 1, 5'd0, 32'hdead, 5'd0, st);
    cyc(0, 1, 5'd0, 32'hbeef, 0, '0, '0, 5'd0, st);
    chk("t4_rf_we", bus.rf_we, 1'b0);
    cyc(0, 0, '0, '0, 0, '0, '0, 5'd0, st);

    // two queued writes to r3: newest wins the forwarding query
    cyc(0, 1, 5'd3, 32'hC, 1, 5'd3, 32'hA, 5'd3, st);
    cyc(0, 1, 5'd3, 32'hC, 1, 5'd3, 32'hB, 5'd3, st);
    chk("t5_q_hit", bus.q_hit, 1'b1);
    chk("t5_q_data", bus.q_data, 32'hB);
    chk("t5_pend", bus.pend_mask, 32'h8);
    cyc(0, 1, 5'd3, 32'hC, 0, '0, '0, 5'd3, st);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 0, '0, '0, 5'd3, st);

    // fill the FIFO behind a busy ALU, hit full, then reset mid-operation
    for (int i = 0; i < 5; i++) cyc(0, 1, 5'd7, 32'h70 + 32'(i), 1, WA'(10 + i), 32'hA0 + 32'(i), 5'd12, st);
    chk("t6_full_ready", bus.lng_ready, 1'b0);
    cyc(1, 1, 5'd7, 32'h77, 0, '0, '0, 5'd12, st);
    rst           = 1'b0;
    bus.alu_valid = 1'b0;
    bus.lng_valid = 1'b0;
    #1;
    chk("t6_rf_we", bus.rf_we, 1'b0);
    chk("t6_pend", bus.pend_mask, 32'd0);
    chk("t6_ready", bus.lng_ready, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0, '0, '0, 5'd12, st);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
